// File: rtl/ps2_scancode_sequencer_if.sv
// rtl/ps2_scancode_sequencer_if.sv - byte-in / event-out handshake bundle for the PS/2 scancode sequencer
interface ps2_scancode_sequencer_if;
    logic [7:0] byte_data;
    logic       byte_en;
    logic       event_valid;
    logic       event_ready;
    logic [7:0] event_code;
    logic       event_ext;
    logic       event_break;

    modport master (
        input  byte_data,
        input  byte_en,
        input  event_ready,
        output event_valid,
        output event_code,
        output event_ext,
        output event_break
    );

    modport slave (
        output byte_data,
        output byte_en,
        output event_ready,
        input  event_valid,
        input  event_code,
        input  event_ext,
        input  event_break
    );
endinterface

// File: rtl/ps2_scancode_sequencer.sv
// rtl/ps2_scancode_sequencer.sv - PS/2 prefix decoder, key-event FIFO, held-key bitmap and watchdog
module ps2_scancode_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic                          clk,
    input  logic                          reset,
    ps2_scancode_sequencer_if.master      bus,
    input  logic                          clear_err,
    output logic [4:0]                    held,
    output logic                          overflow_err,
    output logic                          timeout_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              emit;
    logic              emit_ext;
    logic              emit_brk;
    logic              timeout_hit;
    logic [WD_W-1:0]   wd_cnt;
    logic [7:0]        in_byte;
    logic              is_status;

    logic [9:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop;
    logic              push;
    logic              full;
    logic [4:0]        key_hit;

    assign in_byte = bus.byte_data;

    // Keyboard self-test / ack / resend / error bytes carry no key information.
    assign is_status = (in_byte == 8'h00) || (in_byte == 8'hFF) || (in_byte == 8'hAA) ||
                       (in_byte == 8'hFA) || (in_byte == 8'hEE) || (in_byte == 8'hFE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        emit        = 1'b0;
        emit_ext    = 1'b0;
        emit_brk    = 1'b0;
        timeout_hit = 1'b0;
        if (bus.byte_en) begin
            case (state)
                IDLE: begin
                    if (in_byte == 8'hE0) begin
                        state_next = GOT_E0;
                    end else if (in_byte == 8'hF0) begin
                        state_next = GOT_F0;
                    end else if (!is_status) begin
                        emit = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (in_byte == 8'hF0) begin
                        state_next = GOT_E0F0;
                    end else if (in_byte == 8'hE0) begin
                        state_next = GOT_E0;
                    end else begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: begin
                    // A prefix after F0 is a protocol error: restart the sequence from that prefix.
                    if (in_byte == 8'hE0) begin
                        state_next = GOT_E0;
                    end else if (in_byte == 8'hF0) begin
                        state_next = GOT_F0;
                    end else begin
                        emit       = 1'b1;
                        emit_ext   = (state == GOT_E0F0);
                        emit_brk   = 1'b1;
                        state_next = IDLE;
                    end
                end
            endcase
        end else if (state != IDLE && wd_cnt == WD_MAX) begin
            state_next  = IDLE;
            timeout_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.byte_en || state == IDLE || wd_cnt == WD_MAX) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign full = (count == CNT_FULL);
    assign pop  = bus.event_valid & bus.event_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = emit & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {emit_ext, emit_brk, in_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.event_valid = (count != '0);
    assign {bus.event_ext, bus.event_break, bus.event_code} = mem[rd_ptr];

    always_comb begin
        key_hit    = '0;
        key_hit[0] = emit_ext  && (in_byte == 8'h75);
        key_hit[1] = emit_ext  && (in_byte == 8'h72);
        key_hit[2] = emit_ext  && (in_byte == 8'h6B);
        key_hit[3] = emit_ext  && (in_byte == 8'h74);
        key_hit[4] = !emit_ext && (in_byte == 8'h29);
    end

    // held tracks the keyboard, not the FIFO, so it updates even when the event is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            held <= '0;
        end else if (emit) begin
            held <= (held & ~key_hit) | (key_hit & {5{~emit_brk}});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (emit && !push) begin
                overflow_err <= 1'b1;
            end else if (clear_err) begin
                overflow_err <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// tb/tb_ps2_scancode_sequencer.sv - directed bench with queue-based event model for ps2_scancode_sequencer
module tb_ps2_scancode_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_err;
    logic [4:0] held;
    logic       overflow_err;
    logic       timeout_err;

    ps2_scancode_sequencer_if bus();

    ps2_scancode_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .clear_err    (clear_err),
        .held         (held),
        .overflow_err (overflow_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: pending prefixes as two flags, events as a queue of {ext,brk,code}.
    logic [9:0] q[$];
    logic [4:0] m_held = '0;
    bit         m_ovf = 1'b0;
    bit         m_tmo = 1'b0;
    bit         pend_e0 = 1'b0;
    bit         pend_f0 = 1'b0;
    bit         started = 1'b0;
    int         edge_n = 0;
    int         last_byte_edge = 0;
    logic [7:0] mb;
    bit         m_emit, m_ext, m_brk, m_pop, m_full, new_ovf, new_tmo;
    logic [7:0] key_code [5] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29};
    bit         key_ext  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    function automatic bit status_byte(input logic [7:0] b);
        return b == 8'h00 || b == 8'hFF || b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        started = 1'b1;
        if (reset) begin
            q.delete();
            m_held = '0; m_ovf = 1'b0; m_tmo = 1'b0;
            pend_e0 = 1'b0; pend_f0 = 1'b0;
        end else begin
            m_emit = 1'b0; m_ext = 1'b0; m_brk = 1'b0; new_ovf = 1'b0; new_tmo = 1'b0;
            mb = bus.byte_data;
            m_pop  = (q.size() != 0) && bus.event_ready;
            m_full = (q.size() >= DEPTH);
            if (bus.byte_en) begin
                last_byte_edge = edge_n;
                if (mb == 8'hE0) begin
                    pend_e0 = 1'b1; pend_f0 = 1'b0;
                end else if (mb == 8'hF0) begin
                    if (pend_f0) pend_e0 = 1'b0;
                    pend_f0 = 1'b1;
                end else if (!pend_e0 && !pend_f0 && status_byte(mb)) begin
                    m_emit = 1'b0;
                end else begin
                    m_emit = 1'b1; m_ext = pend_e0; m_brk = pend_f0;
                    pend_e0 = 1'b0; pend_f0 = 1'b0;
                end
            end else if ((pend_e0 || pend_f0) && (edge_n - last_byte_edge >= TMO)) begin
                pend_e0 = 1'b0; pend_f0 = 1'b0; new_tmo = 1'b1;
            end
            if (m_pop) void'(q.pop_front());
            if (m_emit) begin
                if (!m_full || m_pop) q.push_back({m_ext, m_brk, mb});
                else new_ovf = 1'b1;
                for (int k = 0; k < 5; k++)
                    if (mb == key_code[k] && m_ext == key_ext[k]) m_held[k] = !m_brk;
            end
            if (clear_err) begin m_ovf = 1'b0; m_tmo = 1'b0; end
            if (new_ovf) m_ovf = 1'b1;
            if (new_tmo) m_tmo = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("valid", 32'(bus.event_valid), 32'(q.size() != 0));
            if (q.size() != 0)
                chk("head", 32'({bus.event_ext, bus.event_break, bus.event_code}), 32'(q[0]));
            chk("held", 32'(held), 32'(m_held));
            chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
            chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.byte_data = b;
        bus.byte_en   = 1'b1;
        tick();
        bus.byte_en   = 1'b0;
    endtask

    task automatic pop1();
        bus.event_ready = 1'b1;
        tick();
        bus.event_ready = 1'b0;
    endtask

    task automatic clr();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    task automatic head_is(input string name, input logic [7:0] code, input bit ext, input bit brk);
        chk({name, "_valid"}, 32'(bus.event_valid), 32'd1);
        chk(name, 32'({bus.event_ext, bus.event_break, bus.event_code}), 32'({ext, brk, code}));
    endtask

    initial begin
        reset = 1'b1; clear_err = 1'b0;
        bus.byte_data = 8'h00; bus.byte_en = 1'b0; bus.event_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", 32'(bus.event_valid), 32'd0);
        chk("rst_held", 32'(held), 32'd0);
        chk("rst_errs", 32'({overflow_err, timeout_err}), 32'd0);

        send(8'h1C);
        head_is("make_1c", 8'h1C, 1'b0, 1'b0);
        pop1();
        chk("popped_empty", 32'(bus.event_valid), 32'd0);
        send(8'hF0); send(8'h1C);
        head_is("break_1c", 8'h1C, 1'b0, 1'b1);
        chk("held_1c", 32'(held), 32'd0);
        pop1();

        send(8'hE0); send(8'h75);
        chk("held_up_set", 32'(held), 32'h01);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("held_up_clr", 32'(held), 32'h00);
        head_is("ev_up_make", 8'h75, 1'b1, 1'b0);
        pop1();
        head_is("ev_up_break", 8'h75, 1'b1, 1'b1);
        pop1();
        send(8'h75);
        chk("held_75_noext", 32'(held), 32'h00);
        head_is("ev_75_noext", 8'h75, 1'b0, 1'b0);
        pop1();

        for (int i = 1; i <= 6; i++) send(8'(i));
        chk("ovf_set", 32'(overflow_err), 32'd1);
        chk("model_q4", 32'(q.size()), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            head_is("drain", 8'(i), 1'b0, 1'b0);
            pop1();
        end
        chk("drained", 32'(bus.event_valid), 32'd0);
        clr();
        chk("ovf_clr", 32'(overflow_err), 32'd0);

        for (int i = 8'h11; i <= 8'h14; i++) send(8'(i));
        bus.byte_data = 8'h07; bus.byte_en = 1'b1; bus.event_ready = 1'b1;
        tick();
        bus.byte_en = 1'b0; bus.event_ready = 1'b0;
        chk("full_pushpop_ovf", 32'(overflow_err), 32'd0);
        head_is("full_pushpop_head", 8'h12, 1'b0, 1'b0);
        pop1(); head_is("tail13", 8'h13, 1'b0, 1'b0);
        pop1(); head_is("tail14", 8'h14, 1'b0, 1'b0);
        pop1(); head_is("tail07", 8'h07, 1'b0, 1'b0);
        pop1();

        send(8'hE0);
        repeat (TMO - 1) tick();
        chk("tmo_early", 32'(timeout_err), 32'd0);
        tick();
        chk("tmo_set", 32'(timeout_err), 32'd1);
        send(8'h75);
        head_is("after_tmo", 8'h75, 1'b0, 1'b0);
        chk("after_tmo_held", 32'(held), 32'd0);
        pop1();
        clr();
        chk("tmo_clr", 32'(timeout_err), 32'd0);

        send(8'hF0); send(8'hE0); send(8'h75);
        head_is("f0_e0_restart", 8'h75, 1'b1, 1'b0);
        chk("restart_held", 32'(held), 32'h01);
        send(8'hE0); send(8'hF0); send(8'hF0); send(8'h75);
        chk("e0f0f0_held", 32'(held), 32'h01);
        pop1();
        head_is("e0f0f0_ev", 8'h75, 1'b0, 1'b1);
        pop1();
        send(8'hE0); send(8'hE0); send(8'h6B);
        chk("left_held", 32'(held), 32'h05);
        pop1();

        send(8'hAA); send(8'hFA); send(8'h00);
        chk("status_none", 32'(bus.event_valid), 32'd0);
        send(8'hF0);
        reset = 1'b1; bus.byte_data = 8'h29; bus.byte_en = 1'b1;
        tick();
        reset = 1'b0; bus.byte_en = 1'b0;
        chk("rst_byte_ignored", 32'(bus.event_valid), 32'd0);
        chk("rst_held0", 32'(held), 32'd0);
        send(8'h29);
        head_is("space_make", 8'h29, 1'b0, 1'b0);
        chk("space_held", 32'(held), 32'h10);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_sequencer.md
# ps2_scancode_sequencer

Sequences raw PS/2 receiver bytes into complete key events for the game logic. It consumes the 8-bit byte stream and one-cycle strobe produced by the PS/2 receive controller, and tracks the extended (0xE0) and break (0xF0) prefixes. Each event is pushed into a small FIFO with a valid/ready output handshake, and a live held-key bitmap is kept for the game's control keys. A watchdog discards partial prefix sequences if the keyboard goes silent.

## Interface
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 2500000: clk cycles (50 ms at 50 MHz) allowed between bytes of one sequence; ≥2.
- clk  input  1  system clock; only clock.
- reset  input  1  synchronous, active-high reset.
- byte_data  input  8  byte from PS/2 receiver; sampled only when byte_en=1.
- byte_en  input  1  one-cycle strobe: byte_data is a new received byte.
- event_ready  input  1  consumer accepts head event this cycle.
- clear_err  input  1  clears sticky error flags.
- event_valid  output  1  FIFO non-empty; head event presented.
- event_code  output  8  head event scan code (prefixes stripped).
- event_ext  output  1  head event was E0-prefixed.
- event_break  output  1  head event is a release (F0-prefixed).
- held  output  5  held keys: [0] up (E0 75), [1] down (E0 72), [2] left (E0 6B), [3] right (E0 74), [4] space (29).
- overflow_err  output  1  sticky: an event was dropped on a full FIFO.
- timeout_err  output  1  sticky: a partial sequence was discarded by the watchdog.

## Operation
- Decoder FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. It transitions only on byte_en=1, except on timeout.
- IDLE:
  - 0xE0 -> GOT_E0.
  - 0xF0 -> GOT_F0.
  - 0x00, 0xFF, 0xAA, 0xFA, 0xEE, 0xFE are keyboard status/error bytes: discard and stay in IDLE.
  - Any other byte: emit make event {code, ext=0, brk=0}.
- GOT_E0:
  - 0xF0 -> GOT_E0F0.
  - 0xE0 -> stay in GOT_E0.
  - Any other byte: emit {code, ext=1, brk=0} -> IDLE.
- GOT_F0:
  - 0xE0 or 0xF0 is a protocol error: discard, restart as if in IDLE (E0 -> GOT_E0, F0 -> GOT_F0).
  - Any other byte: emit {code, ext=0, brk=1} -> IDLE.
- GOT_E0F0:
  - 0xE0 or 0xF0: same restart rule as GOT_F0.
  - Any other byte: emit {code, ext=1, brk=1} -> IDLE.
- Emit:
  - Push to the FIFO if it is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise drop the event and set overflow_err. held still updates.
- held: a matching make sets its bit and a matching break clears it. Codes must match both code and ext (e.g. 0x75 without E0 does not affect held[0]).
- FIFO: circular, write/read pointers of log2(FIFO_DEPTH) bits that wrap, plus a count register of log2(FIFO_DEPTH)+1 bits.
  - Pop happens when event_valid & event_ready.
  - event_* outputs are driven from the head entry. When empty they hold the last head contents; consumers must ignore them.
- Watchdog:
  - The counter clears on every byte_en and whenever the state is IDLE.
  - It increments each cycle in a non-IDLE state.
  - On reaching TIMEOUT_CYCLES-1: state -> IDLE, timeout_err set, no event emitted.
- clear_err: clears both sticky flags. If a new error coincides with clear_err in the same cycle, the error wins (flag set).
- Reset: state IDLE, FIFO empty, all pointers/counters 0, held=0, errors 0. It also discards any partial sequence; a byte_en in the reset cycle is ignored.

## Timing
- All outputs are registered or derived from registers; no combinational path from byte_en to outputs.
- Latency: byte_en at edge N -> event_valid=1 and held updated after edge N (visible in cycle N+1).
- Back-to-back byte_en on consecutive cycles must be handled; each byte is processed in its own cycle.
- Pop: the next head is visible in the cycle after the accepting edge. The FIFO sustains one push and one pop per cycle.
- Push and pop in the same cycle with count=FIFO_DEPTH: both happen, count unchanged, no overflow.
- Push and pop in the same cycle with count=0: only the push happens (event_valid was 0).
- Timeout: a prefix byte at edge N with no further byte_en -> IDLE and timeout_err=1 after edge N+TIMEOUT_CYCLES.

## Test plan
- Byte 0x1C -> one event {1C, ext0, brk0}. Then F0,1C -> {1C, ext0, brk1}. held unchanged.
- E0,75 then E0,F0,75 -> held[0] 0->1->0. Events {75,1,0} and {75,1,1} in order. 0x75 alone -> held[0] stays 0.
- event_ready=0, FIFO_DEPTH=4, six make codes 0x01..0x06 -> 4 events queued (01..04), overflow_err=1. Draining yields 01,02,03,04. clear_err -> overflow_err=0.
- FIFO full, event_ready=1 while byte_en delivers 0x07 -> no overflow, count stays 4, 0x07 at tail.
- TIMEOUT_CYCLES=8: byte E0 then idle -> timeout_err=1 after 8 cycles. Next byte 0x75 -> event {75, ext0}.
- Bytes 0xAA, 0xFA, 0x00 -> no events. reset asserted after F0 -> next 0x29 is a make event, held[4]=1.
